// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for a shared snooping bus: grants one core at a time,
// broadcasts the owner's transaction and folds every core's cache hit into the others.
module shared_bus_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned HOLD_MAX  = 16,
  parameter int unsigned OWNER_W   = $clog2(NUM_CORES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      req_core,
  input  logic [2*NUM_CORES-1:0]    core_bus_operation_in,
  input  logic [32*NUM_CORES-1:0]   core_bus_address_in,
  input  logic [32*NUM_CORES-1:0]   core_bus_data_in,
  input  logic [NUM_CORES-1:0]      core_cache_hit_in,
  output logic [NUM_CORES-1:0]      grant,
  output logic [1:0]                bus_operation_out,
  output logic [31:0]               bus_address_out,
  output logic [31:0]               bus_data_out,
  output logic                      bus_valid,
  output logic [OWNER_W-1:0]        bus_owner,
  output logic [NUM_CORES-1:0]      snoop_hit_out,
  output logic                      timeout_pulse
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MAX);
  localparam logic [1:0]  OP_NON = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [NUM_CORES-1:0]   r_grant;
  logic [1:0]             r_op;
  logic [31:0]            r_addr;
  logic [31:0]            r_data;
  logic                   r_valid;
  logic [OWNER_W-1:0]     r_owner;
  logic [OWNER_W-1:0]     r_last_owner;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_timeout;

  logic [NUM_CORES-1:0]   w_grant_nxt;
  logic [1:0]             w_op_nxt;
  logic [31:0]            w_addr_nxt;
  logic [31:0]            w_data_nxt;
  logic                   w_valid_nxt;
  logic [OWNER_W-1:0]     w_owner_nxt;
  logic [OWNER_W-1:0]     w_last_nxt;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic                   w_timeout_nxt;

  logic                   w_found;
  logic [OWNER_W-1:0]     w_sel;
  int unsigned            w_dist;
  int unsigned            w_best;
  logic [1:0]             w_own_op;
  logic [31:0]            w_own_addr;
  logic [31:0]            w_own_data;
  logic                   w_owner_req;
  logic                   w_hold_max;
  logic                   w_exit;
  logic                   w_force;
  logic [NUM_CORES-1:0]   w_snoop;

  // Round-robin pick: requester with the smallest distance past last_owner.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_best  = NUM_CORES;
    w_dist  = 0;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      w_dist = (c + 2 * NUM_CORES - 1 - 32'(r_last_owner)) % NUM_CORES;
      if (req_core[c] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_sel   = OWNER_W'(c);
        w_found = 1'b1;
      end
    end
  end

  assign w_own_op    = core_bus_operation_in[{r_owner, 1'b0} +: 2];
  assign w_own_addr  = core_bus_address_in[{r_owner, 5'b0} +: 32];
  assign w_own_data  = core_bus_data_in[{r_owner, 5'b0} +: 32];
  assign w_owner_req = req_core[r_owner];
  assign w_hold_max  = (r_hold == HOLD_W'(HOLD_MAX - 1));
  assign w_exit      = !w_owner_req || w_hold_max;
  assign w_force     = w_owner_req && w_hold_max;

  // Each core sees the OR of everyone else's hit, never its own.
  always_comb begin
    w_snoop = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
        if (i != j) w_snoop[i] = w_snoop[i] | core_cache_hit_in[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_GRANT;
      S_GRANT:   if (w_exit)  w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered bus outputs; address/data hold outside GRANT.
  always_comb begin
    w_grant_nxt   = r_grant;
    w_op_nxt      = r_op;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last_owner;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_op_nxt    = OP_NON;
        w_valid_nxt = 1'b0;
        if (w_found) begin
          w_grant_nxt = NUM_CORES'(1) << w_sel;
          w_owner_nxt = w_sel;
          w_hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_exit) begin
          w_grant_nxt   = '0;
          w_op_nxt      = OP_NON;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = w_force;
        end else begin
          w_op_nxt    = w_own_op;
          w_addr_nxt  = w_own_addr;
          w_data_nxt  = w_own_data;
          w_valid_nxt = (w_own_op != OP_NON);
          if (!w_hold_max) w_hold_nxt = r_hold + 1'b1;
        end
      end
      S_RELEASE: begin
        w_grant_nxt = '0;
        w_op_nxt    = OP_NON;
        w_valid_nxt = 1'b0;
        w_last_nxt  = r_owner;
      end
      default: begin
        w_grant_nxt = '0;
        w_op_nxt    = OP_NON;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= '0;
      r_op         <= OP_NON;
      r_addr       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= OWNER_W'(NUM_CORES - 1);
      r_hold       <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_op         <= w_op_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_hold       <= w_hold_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign grant             = r_grant;
  assign bus_operation_out = r_op;
  assign bus_address_out   = r_addr;
  assign bus_data_out      = r_data;
  assign bus_valid         = r_valid;
  assign bus_owner         = r_owner;
  assign timeout_pulse     = r_timeout;
  assign snoop_hit_out     = w_snoop;

endmodule
